// File: rtl/tlul_arb_pkg.sv
// Shared types and limits for the two-host TL-UL arbiter.
package tlul_arb_pkg;

  // Host identifier: 0 = IFU (h0), 1 = LSU (h1).
  typedef logic host_id_t;

  localparam int NumHosts = 2;
  localparam int DepthMin = 2;
  localparam int DepthMax = 16;
  // Wide enough to hold a count equal to DepthMax.
  localparam int CntW     = $clog2(DepthMax + 1);

  localparam host_id_t HostH0 = 1'b0;
  localparam host_id_t HostH1 = 1'b1;

  // With two hosts the round-robin alternative is simply the other one.
  function automatic host_id_t other_host(input host_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel structs shared by hosts, device and the arbiter.
package tlul_pkg;

  // Host-to-device: A channel request plus the D channel ready.
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  // Device-to-host: D channel response plus the A channel ready.
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_idfifo.sv
// In-order FIFO of host IDs, one entry per outstanding A-channel transaction.
// Pointers wrap at Depth, so non-power-of-two depths are handled.
module tlul_arb_idfifo
  import tlul_arb_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  host_id_t        push_id_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output host_id_t        head_o,
  output logic [CntW-1:0] count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  host_id_t        mem [Depth];
  logic [PtrW-1:0] wr_ptr_reg;
  logic [PtrW-1:0] rd_ptr_reg;
  logic [CntW-1:0] count_reg;
  logic            push_eff;
  logic            pop_eff;

  assign full_o   = (count_reg == CntW'(Depth));
  assign empty_o  = (count_reg == '0);
  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i && !empty_o;
  assign head_o   = mem[rd_ptr_reg];
  assign count_o  = count_reg;

  // Storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    if (push_eff) begin
      mem[wr_ptr_reg] <= push_id_i;
    end
  end

  // Pointer and occupancy update; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr_reg <= (wr_ptr_reg == PtrW'(Depth - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr_reg <= (rd_ptr_reg == PtrW'(Depth - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/tlul_host_arb.sv
// Two-host TL-UL arbiter (IFU on h0, LSU on h1) onto one device port.
// A channel: round-robin grant, locked until the A handshake, zero added latency.
// D channel: responses routed in order via an ID FIFO; orphan beats are dropped
// and flagged on err_o.
// Optional: define TLUL_ARB_PERF_EN to add per-host saturating grant counters.
module tlul_host_arb
  import tlul_pkg::*;
  import tlul_arb_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_h0_i,
  output tl_d2h_t tl_h0_o,
  input  tl_h2d_t tl_h1_i,
  output tl_d2h_t tl_h1_o,
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i,
  output logic    busy_o,
  output logic    err_o
`ifdef TLUL_ARB_PERF_EN
  ,
  output logic [31:0] grant_cnt0_o,
  output logic [31:0] grant_cnt1_o
`endif
);

  // Out-of-range depths are clamped to the supported range.
  localparam int DepthEff = (Depth < DepthMin) ? DepthMin :
                            (Depth > DepthMax) ? DepthMax : Depth;

  tl_h2d_t host_req [NumHosts];

  logic            gnt_valid;
  host_id_t        gnt_id;
  logic            lock_reg;
  host_id_t        lock_id_reg;
  host_id_t        last_reg;
  logic            err_reg;
  logic            busy_reg;

  logic            fifo_full;
  logic            fifo_empty;
  host_id_t        head_id;
  logic [CntW-1:0] fifo_count;

  logic            a_hs;
  logic            pop;
  logic            orphan;
  logic            busy_next;

  logic [NumHosts-1:0] host_sel;
  logic [NumHosts-1:0] host_a_ready;
  logic [NumHosts-1:0] host_d_valid;

  assign host_req[0] = tl_h0_i;
  assign host_req[1] = tl_h1_i;

  // Grant selection: a held lock wins, then round-robin, then whichever host asks.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = HostH0;
    if (lock_reg) begin
      gnt_valid = 1'b1;
      gnt_id    = lock_id_reg;
    end else if (host_req[0].a_valid && host_req[1].a_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = other_host(last_reg);
    end else if (host_req[0].a_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = HostH0;
    end else if (host_req[1].a_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = HostH1;
    end
  end

  // Per-host handshake steering: A ready to the granted host, D valid to the FIFO head.
  genvar gi;
  generate
    for (gi = 0; gi < NumHosts; gi++) begin : g_host
      assign host_sel[gi]     = gnt_valid && (gnt_id == host_id_t'(gi));
      assign host_a_ready[gi] = host_sel[gi] && tl_d_i.a_ready && !fifo_full;
      assign host_d_valid[gi] = tl_d_i.d_valid && !fifo_empty && (head_id == host_id_t'(gi));
    end
  endgenerate

  // Device-side A mux and D ready; an empty FIFO accepts (and drops) any D beat.
  always_comb begin
    tl_d_o         = host_req[gnt_id];
    tl_d_o.a_valid = gnt_valid && host_req[gnt_id].a_valid && !fifo_full;
    tl_d_o.d_ready = fifo_empty ? 1'b1 : host_req[head_id].d_ready;
  end

  // Host-side responses: D payload broadcast, valids and readies qualified per host.
  always_comb begin
    tl_h0_o         = tl_d_i;
    tl_h0_o.a_ready = host_a_ready[0];
    tl_h0_o.d_valid = host_d_valid[0];
    tl_h1_o         = tl_d_i;
    tl_h1_o.a_ready = host_a_ready[1];
    tl_h1_o.d_valid = host_d_valid[1];
  end

  assign a_hs   = tl_d_o.a_valid && tl_d_i.a_ready;
  assign pop    = tl_d_i.d_valid && !fifo_empty && host_req[head_id].d_ready;
  assign orphan = tl_d_i.d_valid && fifo_empty;

  // Next busy equals "FIFO will be non-empty"; push is already blocked when full.
  assign busy_next = a_hs || ((fifo_count != '0) && !(pop && (fifo_count == CntW'(1))));

  tlul_arb_idfifo #(
    .Depth (DepthEff)
  ) u_idfifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (a_hs),
    .push_id_i (gnt_id),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head_id),
    .count_o   (fifo_count)
  );

  // Lock holds the grant while an offered request waits; the handshake releases it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_reg    <= 1'b0;
      lock_id_reg <= HostH0;
      last_reg    <= HostH1;
    end else begin
      if (a_hs) begin
        lock_reg <= 1'b0;
        last_reg <= gnt_id;
      end else if (gnt_valid && host_req[gnt_id].a_valid) begin
        lock_reg    <= 1'b1;
        lock_id_reg <= gnt_id;
      end
    end
  end

  // Sticky orphan-response flag and registered busy indication.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_reg  <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      if (orphan) begin
        err_reg <= 1'b1;
      end
      busy_reg <= busy_next;
    end
  end

  assign err_o  = err_reg;
  assign busy_o = busy_reg;

`ifdef TLUL_ARB_PERF_EN
  logic [NumHosts-1:0][31:0] grant_cnt_reg;

  // Count accepted A beats per host, holding at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_reg <= '0;
    end else begin
      for (int i = 0; i < NumHosts; i++) begin
        if (a_hs && (gnt_id == host_id_t'(i)) && (grant_cnt_reg[i] != '1)) begin
          grant_cnt_reg[i] <= grant_cnt_reg[i] + 32'd1;
        end
      end
    end
  end

  assign grant_cnt0_o = grant_cnt_reg[0];
  assign grant_cnt1_o = grant_cnt_reg[1];
`endif

endmodule
